// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data cache memory-port arbiter.
// Requester ids double as grant-vector bit positions (IC = bit 0, DC = bit 1).
package mem_arb_pkg;

    localparam int LINE_W_DEF = 128;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not granted last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_t       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last == REQ_IC) ? 2'b10 : 2'b01;
            default: o_grant = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache refill and dcache refill/writeback,
// one registered transaction at a time with a one-cycle ready pulse per grant.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            r_state;
    req_t              r_win;
    req_t              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_mem_req;
    logic              r_busy;
    logic              r_ic_ready;
    logic              r_dc_ready;
    logic [LINE_W-1:0] r_ic_line;
    logic [LINE_W-1:0] r_dc_line;

    logic [1:0]        w_grant;

    rr_arb2 u_rr_arb2 (
        .i_req   ({dc_req, ic_req}),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // Per-port capture registers are the rdata outputs, so read data is valid
    // in the same cycle as the ready pulse and holds until that port's next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_win      <= REQ_IC;
            r_last     <= REQ_IC;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_ic_ready <= 1'b0;
            r_dc_ready <= 1'b0;
            r_ic_line  <= '0;
            r_dc_line  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant[1]) begin
                        r_win     <= REQ_DC;
                        r_we      <= dc_we;
                        r_addr    <= dc_addr;
                        r_wdata   <= dc_wdata;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ISSUE;
                    end else if (w_grant[0]) begin
                        r_win     <= REQ_IC;
                        r_we      <= 1'b0;
                        r_addr    <= ic_addr;
                        r_wdata   <= '0;
                        r_mem_req <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (r_win == REQ_IC) begin
                            r_ic_ready <= 1'b1;
                            r_ic_line  <= mem_rdata;
                        end else begin
                            r_dc_ready <= 1'b1;
                            if (!r_we) begin
                                r_dc_line <= mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    r_ic_ready <= 1'b0;
                    r_dc_ready <= 1'b0;
                    r_last     <= r_win;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ic_ready  = r_ic_ready;
    assign ic_rdata  = r_ic_line;
    assign dc_ready  = r_dc_ready;
    assign dc_rdata  = r_dc_line;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected ready pulses
// plus per-scenario checks of the memory-side request.
module tb_mem_port_arbiter;

    localparam int LW = 128;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_ready;
    logic [LW-1:0] ic_rdata;
    logic          dc_req;
    logic          dc_we;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] dc_wdata;
    logic          dc_ready;
    logic [LW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_ready;
    logic [LW-1:0] mem_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            port;  // 0 = IC, 1 = DC
        logic [LW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [LW-1:0] dc_model;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ready  (dc_ready),
        .dc_rdata  (dc_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Scoreboard: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!reset && (ic_ready || dc_ready)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: ic_ready=%0b dc_ready=%0b, required none", ic_ready, dc_ready);
            end else begin
                e = exp_q.pop_front();
                if (ic_ready && dc_ready) begin
                    errors++;
                    $display("FAIL both_ready: ic_ready=1 dc_ready=1, required only one");
                end else if (dc_ready !== e.port) begin
                    errors++;
                    $display("FAIL ready_port: got %s, required %s", dc_ready ? "DC" : "IC", e.port ? "DC" : "IC");
                end else if (e.port && dc_rdata !== e.data) begin
                    errors++;
                    $display("FAIL dc_rdata: got %h, required %h", dc_rdata, e.data);
                end else if (!e.port && ic_rdata !== e.data) begin
                    errors++;
                    $display("FAIL ic_rdata: got %h, required %h", ic_rdata, e.data);
                end
            end
        end
    end

    task automatic wait_mem_req(input string name, output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (mem_req === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: mem_req low for %0d cycles, required high", name, cyc);
    endtask

    // Drive mem_ready in the dly-th cycle of mem_req (caller already saw cycle 1).
    task automatic pulse_ready(input int dly, input logic [LW-1:0] data);
        for (int i = 1; i < dly; i++) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b0) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_idle_timeout: busy=%0b, required 0", name, busy);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ic_req    = 1'($urandom);
            dc_req    = 1'($urandom);
            dc_we     = 1'($urandom);
            ic_addr   = $urandom;
            dc_addr   = $urandom;
            dc_wdata  = {$urandom, $urandom, $urandom, $urandom};
            mem_ready = 1'($urandom);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, ic_ready, dc_ready, busy} !== 5'b0 || mem_addr !== '0 ||
                mem_wdata !== '0 || ic_rdata !== '0 || dc_rdata !== '0) begin
                errors++;
                $display("FAIL reset_outputs: req=%b we=%b icr=%b dcr=%b busy=%b addr=%h, required all 0",
                         mem_req, mem_we, ic_ready, dc_ready, busy, mem_addr);
            end
        end
        ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
        reset = 1'b0;
        dc_model = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_first_tie();
        int cyc;
        logic [LW-1:0] dd, id;
        dd = {4{32'hD0D0_0001}};
        id = {4{32'h1C1C_0002}};
        ic_req = 1; ic_addr = 32'h100;
        dc_req = 1; dc_we = 0; dc_addr = 32'h200;
        exp_q.push_back('{port: 1'b1, data: dd});
        exp_q.push_back('{port: 1'b0, data: id});
        dc_model = dd;
        wait_mem_req("tie_dc", cyc);
        checks++;
        if (mem_addr !== 32'h200 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL tie_first_dc: addr=%h we=%b, required addr=200 we=0", mem_addr, mem_we);
        end
        pulse_ready(1, dd);
        dc_req = 0;
        wait_mem_req("tie_ic", cyc);
        checks++;
        if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL tie_second_ic: addr=%h we=%b, required addr=100 we=0", mem_addr, mem_we);
        end
        pulse_ready(2, id);
        ic_req = 0;
        wait_idle("tie");
    endtask

    task automatic test_ic_read();
        int cyc;
        logic [LW-1:0] a;
        a = {4{32'hAAAA_AAAA}};
        ic_req = 1; ic_addr = 32'h40;
        exp_q.push_back('{port: 1'b0, data: a});
        wait_mem_req("ic_read", cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL ic_read_latency: mem_req after %0d cycles, required 1", cyc);
        end
        checks++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ic_read_req: addr=%h we=%b busy=%b, required addr=40 we=0 busy=1", mem_addr, mem_we, busy);
        end
        pulse_ready(3, a);
        ic_req = 0;
        wait_idle("ic_read");
    endtask

    task automatic test_fairness();
        int cyc;
        logic [LW-1:0] d;
        ic_req = 1; ic_addr = 32'h400;
        dc_req = 1; dc_we = 0; dc_addr = 32'h300;
        for (int t = 0; t < 4; t++) begin
            d = {4{32'h0F00_0000 + 32'(t)}};
            exp_q.push_back('{port: (t % 2 == 0), data: d});
            if (t % 2 == 0) dc_model = d;
            wait_mem_req("fair", cyc);
            checks++;
            if (mem_addr !== ((t % 2 == 0) ? 32'h300 : 32'h400)) begin
                errors++;
                $display("FAIL fair_order_%0d: addr=%h, required %h", t, mem_addr, (t % 2 == 0) ? 32'h300 : 32'h400);
            end
            if (t > 0) begin
                checks++;
                if (cyc != 2) begin
                    errors++;
                    $display("FAIL fair_gap_%0d: mem_req %0d cycles after ready, required 2", t, cyc);
                end
            end
            pulse_ready(1 + t % 2, d);
        end
        ic_req = 0; dc_req = 0;
        wait_idle("fair");
    endtask

    task automatic test_dc_writeback();
        int cyc;
        dc_req = 1; dc_we = 1; dc_addr = 32'h80; dc_wdata = 128'h1234;
        exp_q.push_back('{port: 1'b1, data: dc_model});
        wait_mem_req("wb", cyc);
        dc_addr = 32'hFFFF_0000; dc_wdata = '1; dc_we = 0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 128'h1234) begin
            errors++;
            $display("FAIL wb_req: we=%b addr=%h wdata=%h, required we=1 addr=80 wdata=1234", mem_we, mem_addr, mem_wdata);
        end
        pulse_ready(1, {4{32'hDEAD_BEEF}});
        dc_req = 0;
        wait_idle("wb");
        checks++;
        if (dc_rdata !== dc_model) begin
            errors++;
            $display("FAIL wb_rdata_hold: got %h, required %h", dc_rdata, dc_model);
        end
    endtask

    task automatic test_abort();
        int cyc;
        ic_req = 1; ic_addr = 32'h500;
        wait_mem_req("abort", cyc);
        reset = 1; ic_req = 0;
        @(negedge clk);
        reset = 0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: mem_req=%b busy=%b, required 0 0", mem_req, busy);
        end
        @(negedge clk);
        mem_ready = 1; mem_rdata = {4{32'h5555_5555}};
        @(negedge clk);
        mem_ready = 0; mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || ic_rdata !== '0) begin
                errors++;
                $display("FAIL abort_ignore_%0d: busy=%b mem_req=%b ic_rdata=%h, required 0", i, busy, mem_req, ic_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tie();
        test_ic_read();
        test_fairness();
        test_dc_writeback();
        test_abort();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller that shares the single data-memory port between the instruction-cache refill path and the data-cache refill/writeback path. It sits between both cache controllers and main memory. It arbitrates requests round-robin, sequences each line transfer through a fixed handshake, and returns a one-cycle completion pulse to the winning requester. Only one memory transaction is outstanding at a time.

## Interface
Parameters:
- LINE_W, 128, line width in bits (4 words of 32)
- ADDR_W, 32, byte address width

Ports (reset: synchronous, active-high, named reset; clock: clk):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  icache line-read request, level, held until ic_ready
- ic_addr  in  ADDR_W  icache line address, stable while ic_req
- ic_ready  out  1  one-cycle completion pulse to icache
- ic_rdata  out  LINE_W  line returned to icache, valid when ic_ready
- dc_req  in  1  dcache request, level, held until dc_ready
- dc_we  in  1  1 = line writeback, 0 = line read
- dc_addr  in  ADDR_W  dcache line address
- dc_wdata  in  LINE_W  writeback data
- dc_ready  out  1  one-cycle completion pulse to dcache
- dc_rdata  out  LINE_W  line returned to dcache, valid when dc_ready and !dc_we
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_ready  in  1  memory completion, one-cycle pulse
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, no request: stay.
- IDLE, one or both requests: pick a winner. Latch winner id, we, addr, and wdata into registers. Go to ISSUE.
- Tie-break: the requester not granted last wins. The last-grant register resets to IC, so dcache wins the first tie.
- ISSUE: mem_req=1, and mem_we/addr/wdata come from the latched registers. On mem_ready, capture mem_rdata and go to RESP.
- RESP: pulse ready to the winner for exactly one cycle. Drive its rdata from the capture register. Update last-grant. Go to IDLE.
- Handling of mem_ready:
  - mem_ready outside ISSUE is ignored.
  - mem_rdata is ignored for writes, and dc_rdata keeps its previous value.
- Input changes: once a request is latched, later changes on the ic_*/dc_* inputs have no effect on it.
- Data hold: ic_rdata and dc_rdata hold their last value until the next read completion for that port.
- Reset:
  - All outputs go to 0, the FSM goes to IDLE, and last-grant goes to IC.
  - Reset asserted mid-transaction aborts it: mem_req drops the next cycle and no ready pulse is issued.

## Timing
- All outputs are registered.
- Cycle 0: a request is sampled in IDLE.
- Cycle 1: mem_req rises.
- mem_ready in cycle k (k≥1) → ready pulse in cycle k+1 → IDLE in cycle k+2.
- Minimum request-to-ready latency is 2 cycles. Worst-case wait for the losing requester is one full transaction plus one cycle.
- Requesters must drop req in the cycle after ready. A req still high in IDLE is treated as a new request.
- Back-to-back with both requesters held high: grants alternate, and the next mem_req rises 2 cycles after the previous ready.
- busy is high from cycle 1 through the ready cycle.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP)
  - the requester enum (REQ_IC, REQ_DC)
  - the LINE_W and ADDR_W defaults
- Sub-module rr_arb2: a 2-way round-robin picker. Inputs are req[1:0] and last-grant; output is a one-hot grant. It is combinational.
- The FSM, latch registers, and capture register live in mem_port_arbiter.

## Test plan
- Reset: hold reset for 3 cycles with random inputs → every output is 0; after release, busy=0.
- IC read: ic_req=1, ic_addr=0x40; memory returns 0xA..A after 3 cycles of mem_req → mem_addr=0x40 and mem_we=0, then one ic_ready pulse carrying 0xA..A, with dc_ready=0 throughout.
- First tie: ic_req=dc_req=1 in the first cycle after reset → dcache is served first (mem_addr=dc_addr), then icache. Each completes with a single ready pulse.
- Fairness: hold both requests continuously for 4 transactions → grant order DC, IC, DC, IC.
- DC writeback: dc_we=1, dc_addr=0x80, dc_wdata=0x1234 → mem_we=1, mem_addr=0x80, mem_wdata=0x1234. dc_ready pulses once and dc_rdata is unchanged.
- Abort: assert reset while in ISSUE → mem_req=0 in the next cycle and no ready pulse. A mem_ready arriving 2 cycles later is ignored, and busy stays 0.
